// File: rtl/csa_pkg.sv
//------------------------------------------------------------------------------
// csa_pkg
//   Shared definitions for the pipelined carry-select adder/subtractor.
//   - nseg()            : number of SEG-bit segments in a WIDTH-bit operand
//   - CSA_CHECK_PARAMS  : elaboration-time legality check for WIDTH/SEG
//   - s1_side_t         : stage-1 sideband carried next to the segment results
//                         (operand sign bits needed for the overflow flag)
//------------------------------------------------------------------------------
`ifndef CSA_PKG_SV
`define CSA_PKG_SV

// Expands to a generate-if at module scope; an illegal pairing stops
// elaboration instead of silently building a truncated adder.
`define CSA_CHECK_PARAMS(W, S) \
    if ((((W) % (S)) != 0) || ((S) < 2) || ((W) < (S))) begin : g_illegal_params \
        $error("csa_pipe: WIDTH must be a non-zero multiple of SEG and SEG must be >= 2"); \
    end

package csa_pkg;

    // Number of segments the operands are split into.
    function automatic int nseg(input int width, input int seg);
        return width / seg;
    endfunction

    // Sign bits of the effective operands, registered in stage 1 so the
    // overflow decision in stage 2 does not need the full operands.
    typedef struct packed {
        logic a_msb;
        logic bx_msb;
    } s1_side_t;

endpackage

`endif

// File: rtl/csa_seg.sv
//------------------------------------------------------------------------------
// csa_seg
//   Combinational SEG-bit ripple adder that evaluates both carry-in guesses
//   at once. Stage 1 of csa_pipe registers both results; stage 2 picks one
//   once the real segment carry-in is known.
//
//   Ports:
//     i_a, i_b  in  SEG  segment operands (i_b already inverted for subtract)
//     o_sum0    out SEG  i_a + i_b + 0
//     o_co0     out 1    carry out for carry-in 0
//     o_sum1    out SEG  i_a + i_b + 1
//     o_co1     out 1    carry out for carry-in 1
//------------------------------------------------------------------------------
module csa_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    output logic [SEG-1:0] o_sum0,
    output logic           o_co0,
    output logic [SEG-1:0] o_sum1,
    output logic           o_co1
);

    // Two independent ripple chains; w_c0/w_c1[k] is the carry into bit k.
    logic [SEG:0] w_c0;
    logic [SEG:0] w_c1;
    logic [SEG-1:0] w_p;
    logic [SEG-1:0] w_g;

    assign w_c0[0] = 1'b0;
    assign w_c1[0] = 1'b1;

    for (genvar gi = 0; gi < SEG; gi++) begin : g_bit
        assign w_p[gi]      = i_a[gi] ^ i_b[gi];
        assign w_g[gi]      = i_a[gi] & i_b[gi];
        assign o_sum0[gi]   = w_p[gi] ^ w_c0[gi];
        assign o_sum1[gi]   = w_p[gi] ^ w_c1[gi];
        assign w_c0[gi+1]   = w_g[gi] | (w_p[gi] & w_c0[gi]);
        assign w_c1[gi+1]   = w_g[gi] | (w_p[gi] & w_c1[gi]);
    end

    assign o_co0 = w_c0[SEG];
    assign o_co1 = w_c1[SEG];

endmodule

// File: rtl/csa_pipe.sv
//------------------------------------------------------------------------------
// csa_pipe
//   Two-stage pipelined carry-select adder/subtractor with an elastic
//   valid/ready handshake (two operations in flight, full rate when the
//   consumer never stalls).
//
//   Stage 1: per-segment ripple sums for both carry-in guesses (segment 0
//            uses the real carry-in and stores only its chosen result).
//   Stage 2: carry-select chain across segments, output mux, carry-out and
//            signed overflow.
//
//   Parameters:
//     WIDTH  operand/result width, a multiple of SEG
//     SEG    segment width, >= 2
//   Ports:
//     clock      in   rising-edge clock
//     reset_n    in   asynchronous active-low reset
//     in_valid   in   operation offered
//     in_ready   out  operation accepted when in_valid && in_ready
//     a, b       in   operands
//     ci         in   carry-in for add (ignored when sub = 1)
//     sub        in   0: a + b + ci, 1: a - b
//     out_valid  out  result valid
//     out_ready  in   result consumed when out_valid && out_ready
//     out        out  sum/difference modulo 2^WIDTH
//     co         out  carry out of the MSB (subtract: 1 = no borrow)
//     ovf        out  signed two's-complement overflow
//------------------------------------------------------------------------------
module csa_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             co,
    output logic             ovf
);

    localparam int N = nseg(WIDTH, SEG);

    `CSA_CHECK_PARAMS(WIDTH, SEG)

    //--------------------------------------------------------------------------
    // Handshake
    //--------------------------------------------------------------------------
    logic w_s1_adv;
    logic w_s2_adv;
    logic r_s1_valid;
    logic r_out_valid;

    // S2 may take new data whenever it is empty or being drained this cycle;
    // S1 may refill whenever it is empty or moving into S2. This lets a full
    // pipe drain and refill in the same cycle.
    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    //--------------------------------------------------------------------------
    // Effective operands
    //--------------------------------------------------------------------------
    logic [WIDTH-1:0] w_bx;
    logic             w_cin;

    // Subtract is a + ~b + 1, so the external carry-in is overridden.
    assign w_bx  = sub ? ~b : b;
    assign w_cin = sub | ci;

    //--------------------------------------------------------------------------
    // Stage 1: segment 0 (real carry-in known, single result kept)
    //--------------------------------------------------------------------------
    logic [SEG-1:0] w_sum_lo;
    logic           w_co_lo;
    logic [SEG-1:0] r_sum_lo;
    logic           r_co_lo;
    s1_side_t       w_side;
    s1_side_t       r_side;

    assign {w_co_lo, w_sum_lo} = {1'b0, a[SEG-1:0]}
                               + {1'b0, w_bx[SEG-1:0]}
                               + {{SEG{1'b0}}, w_cin};

    assign w_side.a_msb  = a[WIDTH-1];
    assign w_side.bx_msb = w_bx[WIDTH-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_sum_lo   <= '0;
            r_co_lo    <= 1'b0;
            r_side     <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            r_sum_lo   <= w_sum_lo;
            r_co_lo    <= w_co_lo;
            r_side     <= w_side;
        end
    end

    //--------------------------------------------------------------------------
    // Stage 1 registers and stage 2 select logic for segments 1..N-1
    //--------------------------------------------------------------------------
    // w_c[k] is the resolved carry into segment k (segment 0 already consumed
    // the real carry-in, so the chain starts at its registered carry-out).
    logic [N:1]       w_c;
    logic [WIDTH-1:0] w_out_next;

    assign w_c[1]                = r_co_lo;
    assign w_out_next[SEG-1:0]   = r_sum_lo;

    for (genvar gi = 1; gi < N; gi++) begin : g_seg
        logic [SEG-1:0] w_sum0;
        logic [SEG-1:0] w_sum1;
        logic           w_co0;
        logic           w_co1;
        logic [SEG-1:0] r_sum0;
        logic [SEG-1:0] r_sum1;
        logic           r_co0;
        logic           r_co1;

        csa_seg #(
            .SEG (SEG)
        ) u_seg (
            .i_a    (a[gi*SEG +: SEG]),
            .i_b    (w_bx[gi*SEG +: SEG]),
            .o_sum0 (w_sum0),
            .o_co0  (w_co0),
            .o_sum1 (w_sum1),
            .o_co1  (w_co1)
        );

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_sum0 <= '0;
                r_sum1 <= '0;
                r_co0  <= 1'b0;
                r_co1  <= 1'b0;
            end else if (w_s1_adv) begin
                r_sum0 <= w_sum0;
                r_sum1 <= w_sum1;
                r_co0  <= w_co0;
                r_co1  <= w_co1;
            end
        end

        // One mux level per segment: this chain is the stage-2 critical path.
        assign w_c[gi+1]                  = w_c[gi] ? r_co1  : r_co0;
        assign w_out_next[gi*SEG +: SEG]  = w_c[gi] ? r_sum1 : r_sum0;
    end

    //--------------------------------------------------------------------------
    // Stage 2: result registers
    //--------------------------------------------------------------------------
    logic             w_ovf_next;
    logic [WIDTH-1:0] r_out;
    logic             r_co;
    logic             r_ovf;

    // Overflow only when both effective operands share a sign and the result
    // sign differs from it.
    assign w_ovf_next = (r_side.a_msb == r_side.bx_msb)
                     && (w_out_next[WIDTH-1] != r_side.a_msb);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_co        <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            r_out       <= w_out_next;
            r_co        <= w_c[N];
            r_ovf       <= w_ovf_next;
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign co        = r_co;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_csa_pipe.sv
//------------------------------------------------------------------------------
// tb_csa_pipe
//   Three instances (32/8, 16/4, 64/16) share one clock. A scoreboard holds,
//   per instance, the expected results of accepted operations computed with
//   plain unsigned/signed arithmetic; one compare process checks every valid
//   output against it. Directed tests on the 32-bit instance add literal
//   expectations; the narrow and wide instances run random traffic.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_csa_pipe;

    typedef struct {
        logic [63:0] r;
        logic        co;
        logic        ovf;
    } exp_t;

    int W [3] = '{32, 16, 64};

    logic        clk;
    logic        rn    [3];
    logic        iv    [3];
    logic        ordy  [3];
    logic        ci_d  [3];
    logic        sub_d [3];
    logic [63:0] a_d   [3];
    logic [63:0] b_d   [3];
    logic        ir    [3];
    logic        ov    [3];
    logic        co_d  [3];
    logic        ovf_d [3];
    logic [63:0] out_d [3];

    exp_t        q [3][$];
    logic [63:0] got0 [$];

    int n_vec       = 0;
    int n_checks    = 0;
    int miscompares = 0;

    //--------------------------------------------------------------------------
    // DUTs
    //--------------------------------------------------------------------------
    logic        ir0, ov0, co0, ovf0;
    logic [31:0] o0;
    logic        ir1, ov1, co1, ovf1;
    logic [15:0] o1;
    logic        ir2, ov2, co2, ovf2;
    logic [63:0] o2;

    csa_pipe #(.WIDTH(32), .SEG(8)) u_dut32 (
        .clock(clk), .reset_n(rn[0]), .in_valid(iv[0]), .in_ready(ir0),
        .a(a_d[0][31:0]), .b(b_d[0][31:0]), .ci(ci_d[0]), .sub(sub_d[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .out(o0), .co(co0), .ovf(ovf0)
    );

    csa_pipe #(.WIDTH(16), .SEG(4)) u_dut16 (
        .clock(clk), .reset_n(rn[1]), .in_valid(iv[1]), .in_ready(ir1),
        .a(a_d[1][15:0]), .b(b_d[1][15:0]), .ci(ci_d[1]), .sub(sub_d[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .out(o1), .co(co1), .ovf(ovf1)
    );

    csa_pipe #(.WIDTH(64), .SEG(16)) u_dut64 (
        .clock(clk), .reset_n(rn[2]), .in_valid(iv[2]), .in_ready(ir2),
        .a(a_d[2]), .b(b_d[2]), .ci(ci_d[2]), .sub(sub_d[2]),
        .out_valid(ov2), .out_ready(ordy[2]), .out(o2), .co(co2), .ovf(ovf2)
    );

    assign ir[0] = ir0;  assign ov[0] = ov0;  assign co_d[0] = co0;  assign ovf_d[0] = ovf0;
    assign ir[1] = ir1;  assign ov[1] = ov1;  assign co_d[1] = co1;  assign ovf_d[1] = ovf1;
    assign ir[2] = ir2;  assign ov[2] = ov2;  assign co_d[2] = co2;  assign ovf_d[2] = ovf2;
    assign out_d[0] = {32'd0, o0};
    assign out_d[1] = {48'd0, o1};
    assign out_d[2] = o2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test, required finish before 3ms");
        $fatal(1, "simulation time limit reached");
    end

    //--------------------------------------------------------------------------
    // Behavioural model: a +/- b in wide integer arithmetic
    //--------------------------------------------------------------------------
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic sub);
        exp_t              e;
        logic [63:0]       mask;
        logic [64:0]       ua, ub, us;
        logic signed [67:0] sa, sb, sres, lim;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ua = {1'b0, a & mask};
        ub = {1'b0, b & mask};
        us = sub ? (ua - ub) : (ua + ub + {64'd0, ci});
        e.r  = us[63:0] & mask;
        e.co = sub ? (ua >= ub) : us[w];
        sa = $signed({3'b000, ua});
        sb = $signed({3'b000, ub});
        if (a[w-1]) sa = sa - (68'sd1 <<< w);
        if (b[w-1]) sb = sb - (68'sd1 <<< w);
        sres  = sub ? (sa - sb) : (sa + sb + $signed({67'd0, ci}));
        lim   = 68'sd1 <<< (w - 1);
        e.ovf = (sres >= lim) || (sres < -lim);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    //--------------------------------------------------------------------------
    // Compare process. Handshake signals are stable at the falling edge, so a
    // transfer seen here happens at the next rising edge.
    //--------------------------------------------------------------------------
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rn[d]) begin
                if (ov[d]) begin
                    if (q[d].size() == 0) begin
                        n_checks++;
                        miscompares++;
                        $display("FAIL w%0d_spurious: got out_valid=1 out=%h required out_valid=0 (nothing in flight)",
                                 W[d], out_d[d]);
                    end else begin
                        chk($sformatf("w%0d_out", W[d]), out_d[d], q[d][0].r);
                        chk($sformatf("w%0d_co", W[d]),  co_d[d],  q[d][0].co);
                        chk($sformatf("w%0d_ovf", W[d]), ovf_d[d], q[d][0].ovf);
                        if (ordy[d]) begin
                            if (d == 0) begin
                                got0.push_back(out_d[0]);
                                $display("txn w32 out=%h co=%b ovf=%b", out_d[0], co_d[0], ovf_d[0]);
                            end
                            void'(q[d].pop_front());
                        end
                    end
                end
                if (iv[d] && ir[d]) begin
                    q[d].push_back(model(W[d], a_d[d], b_d[d], ci_d[d], sub_d[d]));
                    n_vec++;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Directed single operation on the 32-bit instance with latency check:
    // accepted at edge t, out_valid rises after edge t+1 (sampled at t+2).
    //--------------------------------------------------------------------------
    task automatic do_op(input string nm, input logic [63:0] av, input logic [63:0] bv,
                         input logic civ, input logic subv,
                         input logic [63:0] eo, input logic eco, input logic eovf);
        int waited = 0;
        a_d[0] = av; b_d[0] = bv; ci_d[0] = civ; sub_d[0] = subv;
        iv[0] = 1'b1; ordy[0] = 1'b1;
        @(negedge clk);
        while (!ir[0] && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!ir[0]) begin
            n_checks++;
            miscompares++;
            $display("FAIL %s_accept: got in_ready=0 required in_ready=1 within 10 cycles", nm);
            iv[0] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        iv[0] = 1'b0;
        chk({nm, "_lat1"}, ov[0], 0);
        @(posedge clk); #1;
        chk({nm, "_valid"}, ov[0], 1);
        chk({nm, "_out"}, out_d[0], eo);
        chk({nm, "_co"}, co_d[0], eco);
        chk({nm, "_ovf"}, ovf_d[0], eovf);
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case ($urandom_range(0, 5))
            0:       return mask;
            1:       return 64'd0;
            2:       return 64'd1 << (w - 1);
            3:       return (64'd1 << (w - 1)) - 64'd1;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    task automatic rand_run(input int d, input int nops);
        int acc = 0;
        int cyc = 0;
        while (acc < nops && cyc < nops * 20) begin
            iv[d]    = ($urandom_range(0, 3) != 0);
            ordy[d]  = ($urandom_range(0, 3) != 0);
            a_d[d]   = pick(W[d]);
            b_d[d]   = pick(W[d]);
            ci_d[d]  = $urandom_range(0, 1) == 1;
            sub_d[d] = $urandom_range(0, 1) == 1;
            @(negedge clk);
            if (iv[d] && ir[d]) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("w%0d_rand_accepted", W[d]), acc, nops);
        iv[d] = 1'b0;
        ordy[d] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    //--------------------------------------------------------------------------
    // Main sequence
    //--------------------------------------------------------------------------
    initial begin
        exp_t m;
        int   acc;
        int   cyc;
        for (int d = 0; d < 3; d++) begin
            rn[d] = 1'b0; iv[d] = 1'b0; ordy[d] = 1'b1;
            ci_d[d] = 1'b0; sub_d[d] = 1'b0; a_d[d] = '0; b_d[d] = '0;
        end

        // Pin the model to hand-computed values.
        m = model(32, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0);
        chk("model_add_ovf", {m.r, m.co, m.ovf}, {64'h8000_0000, 1'b0, 1'b1});
        m = model(16, 64'h8000, 64'd1, 1'b0, 1'b1);
        chk("model_sub_ovf16", {m.r, m.co, m.ovf}, {64'h7FFF, 1'b1, 1'b1});
        m = model(64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
        chk("model_wrap64", {m.r, m.co, m.ovf}, {64'd0, 1'b1, 1'b0});

        // Reset state while reset_n is held low.
        @(negedge clk);
        chk("rst_out_valid", ov[0], 0);
        chk("rst_out", out_d[0], 0);
        chk("rst_co", co_d[0], 0);
        chk("rst_ovf", ovf_d[0], 0);
        chk("rst_in_ready", ir[0], 1);
        @(posedge clk); #3;
        for (int d = 0; d < 3; d++) rn[d] = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic.
        do_op("add_ovf",    64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1);
        do_op("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sub_pos",    64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
        do_op("full_rip",   64'hFFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        do_op("seg_rip",    64'h00FF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0100_0000, 1'b0, 1'b0);
        do_op("sub_ci_ign", 64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0);
        do_op("sub_min",    64'h8000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure: six back-to-back ops, out_ready low in cycles 3..6.
        got0.delete();
        acc = 0;
        cyc = 0;
        while (acc < 6 && cyc < 40) begin
            cyc++;
            ordy[0]  = !(cyc >= 3 && cyc <= 6);
            iv[0]    = 1'b1;
            a_d[0]   = 64'(acc + 1);
            b_d[0]   = 64'(acc + 1);
            ci_d[0]  = 1'b0;
            sub_d[0] = 1'b0;
            @(negedge clk);
            if (cyc >= 3 && cyc <= 6) begin
                chk($sformatf("bp_in_ready_c%0d", cyc), ir[0], 0);
                chk($sformatf("bp_hold_valid_c%0d", cyc), ov[0], 1);
                chk($sformatf("bp_hold_out_c%0d", cyc), out_d[0], 2);
            end
            if (ir[0]) acc++;
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", got0.size(), 6);
        for (int i = 0; i < 6 && i < got0.size(); i++)
            chk($sformatf("bp_order_%0d", i), got0[i], 64'(2 * (i + 1)));

        // Reset with both stages full.
        ordy[0] = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 2 && cyc < 10) begin
            iv[0] = 1'b1; a_d[0] = 64'h100; b_d[0] = 64'h11; ci_d[0] = 1'b0; sub_d[0] = 1'b0;
            @(negedge clk);
            if (ir[0]) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        iv[0] = 1'b0;
        chk("mid_full_in_ready", ir[0], 0);
        chk("mid_pre_out", out_d[0], 64'h111);
        #1;
        rn[0] = 1'b0;
        q[0].delete();
        #1;
        chk("mid_rst_valid", ov[0], 0);
        chk("mid_rst_out", out_d[0], 0);
        chk("mid_rst_co", co_d[0], 0);
        chk("mid_rst_in_ready", ir[0], 1);
        @(posedge clk);
        @(posedge clk); #3;
        rn[0] = 1'b1;
        ordy[0] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("mid_no_stale", ov[0], 0);
        end
        do_op("post_rst", 64'h10, 64'h20, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0);

        // Parametric random sweep on the 16- and 64-bit instances.
        fork
            rand_run(1, 2000);
            rand_run(2, 2000);
        join

        for (int d = 0; d < 3; d++)
            chk($sformatf("w%0d_drained", W[d]), q[d].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
